// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator between decode and execute: one output register plus a
// one-entry skid buffer, so the input side never needs a combinational path from out_ready.
module imm_gen_pipe #(
   parameter int XLEN     = 32,
   parameter int TAG_W    = 8,
   parameter int AUTO_SEL = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [2:0]       in_immsel,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_sel,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   localparam int BW = TAG_W + 1 + 3 + XLEN;

   localparam logic [2:0] SEL_I   = 3'b000;
   localparam logic [2:0] SEL_S   = 3'b001;
   localparam logic [2:0] SEL_B   = 3'b010;
   localparam logic [2:0] SEL_U   = 3'b011;
   localparam logic [2:0] SEL_J   = 3'b100;
   localparam logic [2:0] SEL_Z   = 3'b101;
   localparam logic [2:0] SEL_BAD = 3'b111;

   logic [2:0]      sel_c;
   logic            ill_c;
   logic [XLEN-1:0] imm_c;
   logic [BW-1:0]   beat_c;

   logic [BW-1:0]   main_q, main_d;
   logic [BW-1:0]   skid_q, skid_d;
   logic            main_valid_q, main_valid_d;
   logic            skid_valid_q, skid_valid_d;
   logic            in_xfer, out_xfer;

   always_comb begin : sel_decode
      sel_c = in_immsel;
      if (AUTO_SEL != 0) begin
         case (in_inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: sel_c = SEL_I;
            7'b0100011:                         sel_c = SEL_S;
            7'b1100011:                         sel_c = SEL_B;
            7'b0110111, 7'b0010111:             sel_c = SEL_U;
            7'b1101111:                         sel_c = SEL_J;
            7'b1110011:                         sel_c = in_inst[14] ? SEL_Z : SEL_I;
            default:                            sel_c = SEL_BAD;
         endcase
      end
   end

   // Sized casts of signed operands sign-extend to XLEN; zimm is cast unsigned.
   always_comb begin : extract
      imm_c = '0;
      ill_c = 1'b0;
      case (sel_c)
         SEL_I:   imm_c = XLEN'($signed(in_inst[31:20]));
         SEL_S:   imm_c = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
         SEL_B:   imm_c = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                         in_inst[11:8], 1'b0}));
         SEL_U:   imm_c = XLEN'($signed({in_inst[31:12], 12'b0}));
         SEL_J:   imm_c = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                         in_inst[30:21], 1'b0}));
         SEL_Z:   imm_c = XLEN'(in_inst[19:15]);
         default: ill_c = 1'b1;
      endcase
   end

   assign beat_c = {in_tag, ill_c, sel_c, imm_c};

   // Handshake: a beat moves on a side exactly when valid && ready are both high at the
   // rising edge; in_ready is simply "skid empty", so it is a pure register output.
   assign in_ready = ~skid_valid_q;
   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = main_valid_q & out_ready;

   always_comb begin : next_state
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      if (!main_valid_q || out_xfer) begin
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end else if (in_xfer) begin
            main_d       = beat_c;
            main_valid_d = 1'b1;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (in_xfer) begin
         skid_d       = beat_c;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign out_valid                               = main_valid_q;
   assign {out_tag, out_illegal, out_sel, out_imm} = main_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three instances (XLEN=32, XLEN=64, AUTO_SEL=1) driven from directed
// vectors; each has an expected queue popped by its own monitor on every output transfer.
module tb_imm_gen_pipe;

   localparam int TAG_W = 8;
   localparam int EW    = TAG_W + 1 + 3 + 64;

   // clock / reset
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0]      in_inst;
   logic [2:0]       in_immsel;
   logic [TAG_W-1:0] in_tag;
   logic             out_ready;

   logic             in_valid32, in_ready32, out_valid32, out_ill32;
   logic [31:0]      out_imm32;
   logic [2:0]       out_sel32;
   logic [TAG_W-1:0] out_tag32;

   logic             in_valid64, in_ready64, out_valid64, out_ill64;
   logic [63:0]      out_imm64;
   logic [2:0]       out_sel64;
   logic [TAG_W-1:0] out_tag64;

   logic             in_valida, in_readya, out_valida, out_illa;
   logic [31:0]      out_imma;
   logic [2:0]       out_sela;
   logic [TAG_W-1:0] out_taga;

   logic [EW-1:0] exp_q32[$];
   logic [EW-1:0] exp_q64[$];
   logic [EW-1:0] exp_qa[$];
   logic [EW-1:0] got32, got64, gota;

   int checks = 0;
   int errors = 0;
   int occ32;
   logic        rand_en = 1'b0;
   logic [15:0] ready_pat = 16'b1010_0110_1100_1000;
   int          pat_idx = 0;

   imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W), .AUTO_SEL(0)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
      .in_inst(in_inst), .in_immsel(in_immsel), .in_tag(in_tag),
      .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
      .out_sel(out_sel32), .out_illegal(out_ill32), .out_tag(out_tag32));

   imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W), .AUTO_SEL(0)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
      .in_inst(in_inst), .in_immsel(in_immsel), .in_tag(in_tag),
      .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
      .out_sel(out_sel64), .out_illegal(out_ill64), .out_tag(out_tag64));

   imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W), .AUTO_SEL(1)) u_auto (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valida), .in_ready(in_readya),
      .in_inst(in_inst), .in_immsel(in_immsel), .in_tag(in_tag),
      .out_valid(out_valida), .out_ready(out_ready), .out_imm(out_imma),
      .out_sel(out_sela), .out_illegal(out_illa), .out_tag(out_taga));

   assign got32 = {out_tag32, out_ill32, out_sel32, 32'h0, out_imm32};
   assign got64 = {out_tag64, out_ill64, out_sel64, out_imm64};
   assign gota  = {out_taga, out_illa, out_sela, 32'h0, out_imma};

   task automatic chk(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // beats resident in dut32 (main + skid); skid is full exactly when this is 2
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) occ32 <= 0;
      else occ32 <= occ32 + ((in_valid32 && in_ready32) ? 1 : 0)
                          - ((out_valid32 && out_ready) ? 1 : 0);
   end

   always @(posedge clk) begin
      if (rand_en) begin
         #1;
         out_ready = ready_pat[pat_idx];
         pat_idx   = (pat_idx + 1) % 16;
      end
   end

   // monitors: compare the presented beat with the queue head every cycle, pop on transfer
   always @(negedge clk) begin
      if (rst_n) begin
         chk("dut32_in_ready", EW'(in_ready32), EW'(occ32 < 2));
         if (out_valid32) begin
            if (exp_q32.size() == 0) begin
               checks++; errors++;
               $display("FAIL dut32_unexpected got=%h exp=none", got32);
            end else begin
               chk("dut32_beat", got32, exp_q32[0]);
               if (out_ready) void'(exp_q32.pop_front());
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && out_valid64) begin
         if (exp_q64.size() == 0) begin
            checks++; errors++;
            $display("FAIL dut64_unexpected got=%h exp=none", got64);
         end else begin
            chk("dut64_beat", got64, exp_q64[0]);
            if (out_ready) void'(exp_q64.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && out_valida) begin
         if (exp_qa.size() == 0) begin
            checks++; errors++;
            $display("FAIL auto_unexpected got=%h exp=none", gota);
         end else begin
            chk("auto_beat", gota, exp_qa[0]);
            if (out_ready) void'(exp_qa.pop_front());
         end
      end
   end

   // driver: called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send(input int which, input logic [31:0] inst, input logic [2:0] sel,
                       input logic [TAG_W-1:0] tag, input logic [63:0] eimm,
                       input logic [2:0] esel, input logic eill);
      logic rdy;
      int   budget;
      rdy       = 1'b0;
      budget    = 0;
      in_inst   = inst;
      in_immsel = sel;
      in_tag    = tag;
      case (which)
         0:       in_valid32 = 1'b1;
         1:       in_valid64 = 1'b1;
         default: in_valida  = 1'b1;
      endcase
      while (!rdy && budget < 50) begin
         @(negedge clk);
         rdy = (which == 0) ? in_ready32 : (which == 1) ? in_ready64 : in_readya;
         if (rdy) begin
            case (which)
               0:       exp_q32.push_back({tag, eill, esel, eimm});
               1:       exp_q64.push_back({tag, eill, esel, eimm});
               default: exp_qa.push_back({tag, eill, esel, eimm});
            endcase
         end
         @(posedge clk); #1;
         budget++;
      end
      in_valid32 = 1'b0;
      in_valid64 = 1'b0;
      in_valida  = 1'b0;
      if (!rdy) begin
         checks++; errors++;
         $display("FAIL send_timeout got=stalled exp=accept tag=%h", tag);
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q32.size() + exp_q64.size() + exp_qa.size()) != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain", EW'(exp_q32.size() + exp_q64.size() + exp_qa.size()), '0);
   endtask

   initial begin
      in_valid32 = 1'b0;
      in_valid64 = 1'b0;
      in_valida  = 1'b0;
      in_inst    = '0;
      in_immsel  = '0;
      in_tag     = '0;
      out_ready  = 1'b1;

      repeat (2) @(posedge clk);
      #3;
      chk("rst_valid", EW'({out_valid32, out_valid64, out_valida}), '0);
      chk("rst_data32", got32, '0);
      chk("rst_data64", got64, '0);
      chk("rst_dataa", gota, '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", EW'({in_ready32, in_ready64, in_readya}), EW'(3'b111));

      // XLEN=32, explicit format select
      send(0, 32'hFFF00093, 3'b000, 8'h01, 64'hFFFFFFFF, 3'b000, 1'b0);
      @(negedge clk);
      chk("latency_1", EW'(out_valid32), EW'(1'b1));
      @(posedge clk); #1;
      send(0, 32'hFE000EE3, 3'b010, 8'h02, 64'hFFFFFFFC, 3'b010, 1'b0);
      send(0, 32'h0080006F, 3'b100, 8'h03, 64'h00000008, 3'b100, 1'b0);
      send(0, 32'h00112623, 3'b001, 8'h04, 64'h0000000C, 3'b001, 1'b0);
      send(0, 32'hFE112E23, 3'b001, 8'h05, 64'hFFFFFFFC, 3'b001, 1'b0);
      send(0, 32'h800000B7, 3'b011, 8'h06, 64'h80000000, 3'b011, 1'b0);
      send(0, 32'h0007D073, 3'b101, 8'h07, 64'h0000000F, 3'b101, 1'b0);
      send(0, 32'hFFFFFFFF, 3'b110, 8'h08, 64'h0,        3'b110, 1'b1);
      send(0, 32'hFFFFFFFF, 3'b111, 8'h09, 64'h0,        3'b111, 1'b1);
      send(0, 32'h7FF00093, 3'b000, 8'h0A, 64'h000007FF, 3'b000, 1'b0);
      wait_drain();

      // XLEN=64
      send(1, 32'h800000B7, 3'b011, 8'h11, 64'hFFFFFFFF80000000, 3'b011, 1'b0);
      send(1, 32'h0007D073, 3'b101, 8'h12, 64'h000000000000000F, 3'b101, 1'b0);
      send(1, 32'hFFF00093, 3'b000, 8'h13, 64'hFFFFFFFFFFFFFFFF, 3'b000, 1'b0);
      send(1, 32'h12345037, 3'b011, 8'h14, 64'h0000000012345000, 3'b011, 1'b0);
      send(1, 32'hFE000EE3, 3'b010, 8'h15, 64'hFFFFFFFFFFFFFFFC, 3'b010, 1'b0);
      send(1, 32'h0080006F, 3'b100, 8'h16, 64'h0000000000000008, 3'b100, 1'b0);
      wait_drain();

      // AUTO_SEL=1: in_immsel held at an illegal code to show it is ignored
      send(2, 32'h00000023, 3'b110, 8'h21, 64'h0,        3'b001, 1'b0);
      send(2, 32'h0000007F, 3'b110, 8'h22, 64'h0,        3'b111, 1'b1);
      send(2, 32'hFFF00093, 3'b110, 8'h23, 64'hFFFFFFFF, 3'b000, 1'b0);
      send(2, 32'h0080006F, 3'b110, 8'h24, 64'h00000008, 3'b100, 1'b0);
      send(2, 32'h0007D073, 3'b110, 8'h25, 64'h0000000F, 3'b101, 1'b0);
      send(2, 32'h00000073, 3'b110, 8'h26, 64'h0,        3'b000, 1'b0);
      send(2, 32'h800000B7, 3'b110, 8'h27, 64'h80000000, 3'b011, 1'b0);
      send(2, 32'hFE000EE3, 3'b110, 8'h28, 64'hFFFFFFFC, 3'b010, 1'b0);
      wait_drain();

      // back-pressure: tags 1..6, I-type immediates 100*t, out_ready from a fixed pattern
      rand_en = 1'b1;
      for (int t = 1; t <= 6; t++) begin
         send(0, {12'(t * 100), 20'h00093}, 3'b000, 8'(t), 64'(t * 100), 3'b000, 1'b0);
      end
      wait_drain();
      @(posedge clk); #2;
      rand_en   = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;

      // reset with main and skid both full
      out_ready = 1'b0;
      send(0, 32'hFFF00093, 3'b000, 8'h41, 64'hFFFFFFFF, 3'b000, 1'b0);
      send(0, 32'h0080006F, 3'b100, 8'h42, 64'h00000008, 3'b100, 1'b0);
      @(negedge clk);
      chk("skid_full_ready", EW'(in_ready32), '0);
      chk("skid_full_valid", EW'(out_valid32), EW'(1'b1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", EW'(out_valid32), '0);
      chk("async_rst_data", got32, '0);
      exp_q32.delete();
      @(posedge clk); #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      chk("post_rst_ready", EW'(in_ready32), EW'(1'b1));
      chk("post_rst_valid", EW'(out_valid32), '0);
      send(0, 32'h0007D073, 3'b101, 8'h43, 64'h0000000F, 3'b101, 1'b0);
      wait_drain();
      repeat (5) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
